// File: rtl/spi_slave_core.sv
// spi_slave_core: oversampled SPI slave, all CPOL/CPHA modes, valid/ready TX and RX holding registers.
module spi_slave_core #(
  parameter int DATA_W      = 8,
  parameter int CPOL        = 0,
  parameter int CPHA        = 0,
  parameter int MSB_FIRST   = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sclk,
  input  logic              mosi,
  input  logic              ss_n,
  output logic              miso,
  output logic              miso_oe,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              busy,
  output logic              tx_underrun,
  output logic              rx_overrun
);
  localparam int CW = $clog2(DATA_W);
  typedef enum logic {IDLE, ACTIVE} state_t;
  state_t state;
  logic [SYNC_STAGES-1:0] sclk_sync, mosi_sync, ss_sync;
  logic sclk_d, ss_d, sclk_s, mosi_s, ss_s;
  logic leading, trailing, sample, shift, ss_fall, ss_rise, load, hold_full;
  logic tx_last, rx_last, first_bit, next_bit;
  logic [DATA_W-1:0] hold, tx_sr, rx_sr, rx_nxt, ld_word, sh_sr;
  logic [CW-1:0] tx_cnt, rx_cnt;
  always_comb begin
    sclk_s    = sclk_sync[SYNC_STAGES-1];
    mosi_s    = mosi_sync[SYNC_STAGES-1];
    ss_s      = ss_sync[SYNC_STAGES-1];
    leading   = (sclk_s != sclk_d) && (sclk_d == 1'(CPOL));
    trailing  = (sclk_s != sclk_d) && (sclk_s == 1'(CPOL));
    sample    = (CPHA != 0) ? trailing : leading;
    shift     = (CPHA != 0) ? leading : trailing;
    ss_fall   = ss_d && !ss_s;
    ss_rise   = !ss_d && ss_s;
    tx_last   = tx_cnt == CW'(DATA_W-1);
    rx_last   = rx_cnt == CW'(DATA_W-1);
    rx_nxt    = (MSB_FIRST != 0) ? {rx_sr[DATA_W-2:0], mosi_s} : {mosi_s, rx_sr[DATA_W-1:1]};
    ld_word   = hold_full ? hold : '0;
    first_bit = (MSB_FIRST != 0) ? ld_word[DATA_W-1] : ld_word[0];
    sh_sr     = (MSB_FIRST != 0) ? tx_sr << 1 : tx_sr >> 1;
    next_bit  = (MSB_FIRST != 0) ? tx_sr[DATA_W-2] : tx_sr[1];
    // CPHA=0 preloads at select; CPHA=1 loads on the first shift edge of every word
    load      = (state == IDLE && ss_fall && CPHA == 0) ||
                (state == ACTIVE && !ss_rise && shift && ((CPHA != 0) ? tx_cnt == '0 : tx_last));
  end
  assign tx_ready = !hold_full;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync <= {SYNC_STAGES{1'(CPOL)}};
      mosi_sync <= '0;
      ss_sync   <= '1;
      sclk_d    <= 1'(CPOL);
      ss_d      <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], ss_n};
      sclk_d    <= sclk_s;
      ss_d      <= ss_s;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      busy        <= 1'b0;
      miso_oe     <= 1'b0;
      miso        <= 1'b0;
      hold        <= '0;
      hold_full   <= 1'b0;
      tx_sr       <= '0;
      rx_sr       <= '0;
      tx_cnt      <= '0;
      rx_cnt      <= '0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;
      rx_overrun  <= 1'b0;
    end else begin
      tx_underrun <= 1'b0;
      rx_overrun  <= 1'b0;
      if (rx_valid && rx_ready) rx_valid <= 1'b0;
      if (load) begin
        tx_sr       <= ld_word;
        miso        <= first_bit;
        tx_underrun <= !hold_full;
        hold_full   <= 1'b0;
        tx_cnt      <= (CPHA != 0) ? CW'(1) : '0;
      end else if (state == ACTIVE && !ss_rise && shift) begin
        tx_sr  <= sh_sr;
        miso   <= next_bit;
        tx_cnt <= tx_last ? '0 : tx_cnt + CW'(1);
      end
      // a capture in the same cycle as a load refills the just-emptied register
      if (tx_valid && !hold_full) begin
        hold      <= tx_data;
        hold_full <= 1'b1;
      end
      if (state == IDLE && ss_fall) begin
        state   <= ACTIVE;
        busy    <= 1'b1;
        miso_oe <= 1'b1;
      end else if (state == ACTIVE && ss_rise) begin
        state   <= IDLE;
        busy    <= 1'b0;
        miso_oe <= 1'b0;
        tx_cnt  <= '0;
        rx_cnt  <= '0;
        tx_sr   <= '0;
        rx_sr   <= '0;
      end else if (state == ACTIVE && sample) begin
        rx_sr  <= rx_nxt;
        rx_cnt <= rx_last ? '0 : rx_cnt + CW'(1);
        if (rx_last && (!rx_valid || rx_ready)) begin
          rx_data  <= rx_nxt;
          rx_valid <= 1'b1;
        end else if (rx_last) begin
          rx_overrun <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_spi_slave_core.sv
// tb_spi_slave_core: four slave instances (modes 0/1/3 MSB-first, mode 0 LSB-first) driven by one SPI master model.
module tb_spi_slave_core;
  localparam int H = 80;
  logic clk = 0, rst_n = 0, sclk = 0, mosi = 0;
  logic [3:0] ss_n_v = '1, tx_valid_v = '0, rx_ready_v = '1;
  logic [7:0] tx_data = '0;
  logic [3:0] miso_v, miso_oe_v, tx_ready_v, rx_valid_v, busy_v, und_v, ovr_v;
  logic [7:0] rx_data_v [4];
  int sel = 0, vectors = 0, errs = 0, n_under = 0, n_over = 0;
  logic [7:0] exp_rx[$], exp_tx[$];
  logic [7:0] mw;
  event mword;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 4; g++) begin : g_dut
    spi_slave_core #(.DATA_W(8), .CPOL(g == 2), .CPHA(g == 1 || g == 2), .MSB_FIRST(g != 3), .SYNC_STAGES(2)) u (
      .clk(clk), .rst_n(rst_n), .sclk(sclk), .mosi(mosi), .ss_n(ss_n_v[g]),
      .miso(miso_v[g]), .miso_oe(miso_oe_v[g]), .tx_data(tx_data), .tx_valid(tx_valid_v[g]),
      .tx_ready(tx_ready_v[g]), .rx_data(rx_data_v[g]), .rx_valid(rx_valid_v[g]), .rx_ready(rx_ready_v[g]),
      .busy(busy_v[g]), .tx_underrun(und_v[g]), .rx_overrun(ovr_v[g]));
  end
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s (dut %0d): got %h expected %h", name, sel, got, exp);
    end
  endtask
  // rx scoreboard: pops whenever the selected slave hands over a word
  always @(negedge clk) if (rst_n) begin
    if (und_v[sel]) n_under++;
    if (ovr_v[sel]) n_over++;
    if (rx_valid_v[sel] && rx_ready_v[sel]) begin
      if (exp_rx.size() == 0) begin
        vectors++;
        errs++;
        $display("FAIL rx_unexpected (dut %0d): got %h expected none", sel, rx_data_v[sel]);
      end else check("rx_data", rx_data_v[sel], exp_rx.pop_front());
    end
  end
  always @(mword) begin
    if (exp_tx.size() == 0) begin
      vectors++;
      errs++;
      $display("FAIL miso_unexpected (dut %0d): got %h expected none", sel, mw);
    end else check("miso_word", mw, exp_tx.pop_front());
  end
  task automatic push_tx(input logic [7:0] d);
    int t = 0;
    while (!tx_ready_v[sel] && t < 200) begin
      @(posedge clk);
      t++;
    end
    check("tx_ready_wait", tx_ready_v[sel], 1);
    @(posedge clk);
    #1 tx_data = d;
    tx_valid_v[sel] = 1'b1;
    @(posedge clk);
    #1 tx_valid_v[sel] = 1'b0;
  endtask
  // master: always MSB-first on the wire; words packed MSB-first into data
  task automatic frame(input logic [15:0] data, input int nbits);
    logic cpol = (sel == 2);
    logic cpha = (sel == 1 || sel == 2);
    logic [7:0] r = '0;
    logic s;
    sclk = cpol;
    #(2*H);
    ss_n_v[sel] = 1'b0;
    #H;
    check("busy_on", {busy_v[sel], miso_oe_v[sel]}, 2'b11);
    for (int i = 0; i < nbits; i++) begin
      if (!cpha) begin
        mosi = data[15-i];
        #H;
      end else begin
        sclk = ~cpol;
        mosi = data[15-i];
        #H;
      end
      s = miso_v[sel];
      r = {r[6:0], s};
      sclk = ~sclk;
      #(H/2);
      check("miso_hold", miso_v[sel], s);
      #(H/2);
      if (!cpha) sclk = cpol;
      if (i % 8 == 7) begin
        mw = r;
        ->mword;
      end
    end
    #H;
    ss_n_v[sel] = 1'b1;
    #H;
    check("busy_off", {busy_v[sel], miso_oe_v[sel]}, 2'b00);
  endtask
  initial begin
    int t;
    repeat (3) @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      check("reset_flags", {tx_ready_v[i], rx_valid_v[i], busy_v[i], miso_v[i], miso_oe_v[i], und_v[i], ovr_v[i]}, 7'b1000000);
      check("reset_rx_data", rx_data_v[i], 0);
    end
    rst_n = 1;
    repeat (5) @(posedge clk);
    sel = 0;
    push_tx(8'h3C);
    exp_tx.push_back(8'h3C);
    exp_rx.push_back(8'hA5);
    frame({8'hA5, 8'h00}, 8);
    sel = 2;
    push_tx(8'h3C);
    exp_tx.push_back(8'h3C);
    exp_rx.push_back(8'hA5);
    frame({8'hA5, 8'h00}, 8);
    sel = 1;
    push_tx(8'h3C);
    exp_tx.push_back(8'h3C);
    exp_rx.push_back(8'hA5);
    frame({8'hA5, 8'h00}, 8);
    push_tx(8'h11);
    n_under = 0;
    exp_tx.push_back(8'h11);
    exp_tx.push_back(8'h22);
    exp_rx.push_back(8'h5A);
    exp_rx.push_back(8'hC3);
    fork
      frame({8'h5A, 8'hC3}, 16);
      begin
        #(3*H);
        push_tx(8'h22);
      end
    join
    check("two_word_underrun", n_under, 0);
    sel = 0;
    rx_ready_v[0] = 1'b0;
    n_over = 0;
    exp_tx.push_back(8'h00);
    exp_tx.push_back(8'h00);
    frame({8'h01, 8'h02}, 16);
    check("overrun_valid_held", rx_valid_v[0], 1);
    check("overrun_data_kept", rx_data_v[0], 8'h01);
    check("overrun_pulses", n_over, 1);
    exp_rx.push_back(8'h01);
    @(posedge clk);
    #1 rx_ready_v[0] = 1'b1;
    repeat (4) @(posedge clk);
    check("rx_valid_cleared", rx_valid_v[0], 0);
    sel = 3;
    n_under = 0;
    exp_tx.push_back(8'h00);
    exp_rx.push_back(8'h01);
    fork
      frame({8'h80, 8'h00}, 8);
      begin
        #(3*H);
        push_tx(8'h77);
      end
    join
    check("underrun_pulses", n_under, 1);
    sel = 0;
    frame({8'hFF, 8'h00}, 5);
    exp_tx.push_back(8'h00);
    exp_rx.push_back(8'hF0);
    frame({8'hF0, 8'h00}, 8);
    check("after_abort_rx_data", rx_data_v[0], 8'hF0);
    t = 0;
    while ((exp_rx.size() != 0 || exp_tx.size() != 0) && t < 1000) begin
      @(posedge clk);
      t++;
    end
    check("queues_drained", exp_rx.size() + exp_tx.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
